// File: rtl/plot_framebuffer.sv
// Plot-stream pixel sink: writes vga_* plots into a WIDTHxHEIGHT frame store and
// streams it back in raster order. Define FB_CLEAR_EN to build the zero-fill clear FSM.
module plot_framebuffer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int CW     = 3
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic [7:0]    vga_x,
  input  logic [6:0]    vga_y,
  input  logic [CW-1:0] vga_colour,
  input  logic          vga_plot,
  input  logic          clear,
  output logic          clear_busy,
  input  logic          scan_en,
  output logic          rd_valid,
  output logic [CW-1:0] rd_colour,
  output logic [7:0]    rd_x,
  output logic [6:0]    rd_y,
  output logic          line_end,
  output logic          frame_end,
  output logic [7:0]    drop_count
);

  localparam int         DEPTH  = WIDTH * HEIGHT;
  localparam logic [7:0] X_LIM  = 8'(WIDTH);
  localparam logic [6:0] Y_LIM  = 7'(HEIGHT);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);
  localparam logic [14:0] A_LAST = 15'(DEPTH - 1);

  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return 15'(y) * 15'(WIDTH) + 15'(x);
  endfunction

  logic [CW-1:0] mem [DEPTH];

  logic          clearing;
  logic [14:0]   clr_addr;

`ifdef FB_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  state_t      state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;

  // Reset lands in CLEAR so the store is zero-filled after every reset release.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == A_LAST) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clearing = (state_q == ST_CLEAR);
  assign clr_addr = clr_addr_q;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign clearing     = 1'b0;
  assign clr_addr     = '0;
`endif

  assign clear_busy = clearing;

  // Write port: the clear sweep owns it while active; plots are then rejected.
  logic          in_range;
  logic          plot_reject;
  logic          mem_we;
  logic [14:0]   mem_waddr;
  logic [CW-1:0] mem_wdata;

  assign in_range    = (vga_x < X_LIM) && (vga_y < Y_LIM);
  assign plot_reject = vga_plot && (!in_range || clearing);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = pix_addr(vga_x, vga_y);
    mem_wdata = vga_colour;
    if (clearing) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (vga_plot && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic [7:0] drop_q, drop_d;
  assign drop_d = (plot_reject && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  // Scan side: rd_valid is a one-cycle strobe with no backpressure; each scan_en
  // cycle yields exactly one beat on the next cycle, coordinates travelling with data.
  logic [7:0]    sx_q, sx_d;
  logic [6:0]    sy_q, sy_d;
  logic          rd_valid_q, line_end_q, frame_end_q;
  logic [CW-1:0] rd_colour_q;
  logic [7:0]    rd_x_q;
  logic [6:0]    rd_y_q;
  logic          at_line_end, at_frame_end;

  assign at_line_end  = (sx_q == X_LAST);
  assign at_frame_end = at_line_end && (sy_q == Y_LAST);

  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (scan_en) begin
      if (at_line_end) begin
        sx_d = '0;
        sy_d = at_frame_end ? 7'd0 : sy_q + 7'd1;
      end else begin
        sx_d = sx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sx_q        <= '0;
      sy_q        <= '0;
      rd_valid_q  <= 1'b0;
      rd_colour_q <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      drop_q      <= drop_d;
      rd_valid_q  <= scan_en;
      line_end_q  <= scan_en && at_line_end;
      frame_end_q <= scan_en && at_frame_end;
      if (scan_en) begin
        rd_colour_q <= mem[pix_addr(sx_q, sy_q)];
        rd_x_q      <= sx_q;
        rd_y_q      <= sy_q;
      end
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_colour  = rd_colour_q;
  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign line_end   = line_end_q;
  assign frame_end  = frame_end_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Bench for plot_framebuffer: directed plots/scans feed an expected-beat queue that a
// negedge monitor drains; builds with or without FB_CLEAR_EN.
module tb_plot_framebuffer;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int CW = 3;
  localparam int N  = W * H;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N  = 1'b0;
  logic [7:0]    vga_x = '0;
  logic [6:0]    vga_y = '0;
  logic [CW-1:0] vga_colour = '0;
  logic          vga_plot = 1'b0;
  logic          clear = 1'b0;
  logic          scan_en = 1'b0;
  logic          clear_busy, rd_valid, line_end, frame_end;
  logic [CW-1:0] rd_colour;
  logic [7:0]    rd_x, drop_count;
  logic [6:0]    rd_y;

  plot_framebuffer dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .clear      (clear),
    .clear_busy (clear_busy),
    .scan_en    (scan_en),
    .rd_valid   (rd_valid),
    .rd_colour  (rd_colour),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .line_end   (line_end),
    .frame_end  (frame_end),
    .drop_count (drop_count)
  );

  // ---------------- clock ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

`ifdef FB_CLEAR_EN
  localparam logic BUSY_AT_RESET = 1'b1;
  localparam int   CLR_AT_RESET  = N;
`else
  localparam logic BUSY_AT_RESET = 1'b0;
  localparam int   CLR_AT_RESET  = 0;
`endif

  // ---------------- reference state ----------------
  logic [CW-1:0] model [N];
  int sx_m, sy_m, drop_m, clr_left;
  logic [19:0] exp_q[$];   // {colour, x, y, line_end, frame_end}
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle of inputs, updates the reference, waits one edge.
  task automatic cycle(input logic p, input int x, input int y, input int c,
                       input logic s, input logic clr);
    logic busy;
    int   idx;
    vga_plot   = p;
    vga_x      = x[7:0];
    vga_y      = y[6:0];
    vga_colour = c[CW-1:0];
    scan_en    = s;
    clear      = clr;
    busy       = (clr_left > 0);
    chk("clear_busy", {31'd0, clear_busy}, {31'd0, busy});
    if (s) begin
      idx = sy_m * W + sx_m;
      exp_q.push_back({model[idx], sx_m[7:0], sy_m[6:0],
                       sx_m == W - 1, (sx_m == W - 1) && (sy_m == H - 1)});
      if (sx_m == W - 1) begin
        sx_m = 0;
        sy_m = (sy_m == H - 1) ? 0 : sy_m + 1;
      end else begin
        sx_m = sx_m + 1;
      end
    end
    if (p) begin
      if (x < W && y < H && !busy) model[y * W + x] = c[CW-1:0];
      else if (drop_m < 255) drop_m++;
    end
    if (busy) begin
      clr_left--;
      if (clr_left == 0) for (int i = 0; i < N; i++) model[i] = '0;
    end
`ifdef FB_CLEAR_EN
    else if (clr) clr_left = N;
`endif
    @(posedge CLOCK_50);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLOCK_50) begin
    logic [19:0] e, g;
    if (RESET_N && rd_valid) begin
      g = {rd_colour, rd_x, rd_y, line_end, frame_end};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got x=%0d y=%0d colour=%0d, expected no beat",
                 rd_x, rd_y, rd_colour);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL beat: got c=%0d x=%0d y=%0d le=%0b fe=%0b, expected c=%0d x=%0d y=%0d le=%0b fe=%0b",
                   g[19:17], g[16:9], g[8:2], g[1], g[0],
                   e[19:17], e[16:9], e[8:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) model[i] = '0;
    sx_m = 0; sy_m = 0; drop_m = 0; clr_left = 0;

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_rd_valid",   {31'd0, rd_valid},   0);
    chk("rst_line_end",   {31'd0, line_end},   0);
    chk("rst_frame_end",  {31'd0, frame_end},  0);
    chk("rst_rd_colour",  {29'd0, rd_colour},  0);
    chk("rst_rd_x",       {24'd0, rd_x},       0);
    chk("rst_rd_y",       {25'd0, rd_y},       0);
    chk("rst_drop_count", {24'd0, drop_count}, 0);
    chk("rst_clear_busy", {31'd0, clear_busy}, {31'd0, BUSY_AT_RESET});
    RESET_N  = 1'b1;
    clr_left = CLR_AT_RESET;

    // Bring the store to a known all-zero image.
`ifdef FB_CLEAR_EN
    repeat (N) cycle(0, 0, 0, 0, 0, 0);
`else
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) cycle(1, x, y, 0, 0, 0);
`endif
    chk("init_drop", {24'd0, drop_count}, 0);

    // Clear with plots around it: (1,1) erased, (2,2) dropped while busy (macro build).
    cycle(1, 1, 1, 4, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 2, 2, 5, 0, 0);
`ifdef FB_CLEAR_EN
    chk("clear_drop", {24'd0, drop_count}, 1);
`else
    chk("clear_drop", {24'd0, drop_count}, 0);
`endif
    while (clr_left > 0) cycle(0, 0, 0, 0, 0, 0);

    // Plots and out-of-range rejects.
    cycle(1, 5, 5, 5, 0, 0);
    cycle(1, 160, 0, 7, 0, 0);
    cycle(1, 0, 120, 7, 0, 0);
    chk("reject_drop", {24'd0, drop_count}, drop_m);
    cycle(1, 159, 119, 3, 0, 0);

    // Frame 1, with a same-address plot at (10,2) during its read.
    for (int k = 0; k < N; k++) begin
      if (k == 2 * W + 10) cycle(1, 10, 2, 6, 1, 0);
      else                 cycle(0, 0, 0, 0, 1, 0);
    end
    // Frame 2 up to and including (80,60).
    for (int k = 0; k <= 60 * W + 80; k++) cycle(0, 0, 0, 0, 1, 0);
    scan_en  = 1'b0;
    vga_plot = 1'b0;
    @(negedge CLOCK_50);
    #2;
    chk("pre_reset_queue", exp_q.size(), 0);

    // Asynchronous reset mid-scan.
    RESET_N = 1'b0;
    #1;
    chk("async_rd_valid",  {31'd0, rd_valid},   0);
    chk("async_rd_x",      {24'd0, rd_x},       0);
    chk("async_rd_y",      {25'd0, rd_y},       0);
    chk("async_drop",      {24'd0, drop_count}, 0);
    chk("async_clear_busy", {31'd0, clear_busy}, {31'd0, BUSY_AT_RESET});
    sx_m = 0; sy_m = 0; drop_m = 0; clr_left = 0;
    @(posedge CLOCK_50);
    #1;
    RESET_N  = 1'b1;
    clr_left = CLR_AT_RESET;

    // Scan restarts at (0,0).
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 1, 0);

    // Saturation of the reject counter.
    for (int k = 0; k < 300; k++) cycle(1, 200, 0, 1, 0, 0);
    chk("drop_saturate", {24'd0, drop_count}, 255);
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
